// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the SRL FIFO controller: push/pop operation encoding
// and the occupancy-width helper.
package srl_fifo_pkg;

    // Operation code is {pop, push}.
    localparam logic [1:0] NOP     = 2'b00;
    localparam logic [1:0] PUSH    = 2'b01;
    localparam logic [1:0] POP     = 2'b10;
    localparam logic [1:0] PUSHPOP = 2'b11;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Write/read port bundle of the SRL FIFO controller.
// Optional almost-full/almost-empty flags are present when SRL_FIFO_CTRL_ALMOST_EN is defined.
interface srl_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4
);

    // A push happens on a rising edge where if_write & if_write_ce & if_full_n are all high;
    // a pop happens where if_read & if_read_ce & if_empty_n are all high. if_dout always
    // shows the oldest entry (fall-through), so a pop consumes the value visible that cycle.
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_count;
`ifdef SRL_FIFO_CTRL_ALMOST_EN
    logic                  if_almost_full_n;
    logic                  if_almost_empty_n;
`endif

`ifdef SRL_FIFO_CTRL_ALMOST_EN
    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n, if_count,
        input  if_almost_full_n, if_almost_empty_n
    );
    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n, if_count,
        output if_almost_full_n, if_almost_empty_n
    );
`else
    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n, if_count
    );
    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n, if_count
    );
`endif

endinterface

// File: rtl/srl_fifo_shiftreg.sv
// FIFO storage: write-enabled shift chain with an addressed combinational read.
// Entry 0 is the newest word; no reset so it maps onto SRL primitives.
module srl_fifo_shiftreg
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  shift_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Addresses beyond DEPTH only occur when the FIFO is empty; return zero there.
    always_comb begin
        data_o = '0;
        if (int'(addr_i) < DEPTH) begin
            data_o = mem_q[addr_i];
        end
    end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// First-word fall-through FIFO controller around an SRL shift chain.
// Define SRL_FIFO_CTRL_ALMOST_EN to add the registered almost-full/almost-empty flags.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
`ifdef SRL_FIFO_CTRL_ALMOST_EN
    ,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
    srl_fifo_ctrl_if.slave fifo
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0]      count_q, count_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  push, pop;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // Flags are registered, so gating on them gives the legal operation at full/empty.
    assign push = fifo.if_write & fifo.if_write_ce & full_n_q;
    assign pop  = fifo.if_read  & fifo.if_read_ce  & empty_n_q;
    assign op   = {pop, push};

    always_comb begin
        count_d = count_q;
        case (op)
            PUSH:    count_d = count_q + OCC_W'(1);
            POP:     count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign full_n_d  = (count_d != OCC_W'(DEPTH));
    assign empty_n_d = (count_d != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    // Oldest word sits at count-1; a push shifts it one place deeper as count grows,
    // and a push+pop shifts while the address holds, exposing the next-oldest word.
    assign rd_addr = ADDR_WIDTH'(count_q - OCC_W'(1));

    srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk        (clk),
        .shift_en_i (push & reset_n),
        .data_i     (fifo.if_din),
        .addr_i     (rd_addr),
        .data_o     (rd_data)
    );

    assign fifo.if_dout    = empty_n_q ? rd_data : '0;
    assign fifo.if_full_n  = full_n_q;
    assign fifo.if_empty_n = empty_n_q;
    assign fifo.if_count   = (ADDR_WIDTH+1)'(count_q);

`ifdef SRL_FIFO_CTRL_ALMOST_EN
    logic almost_full_n_q, almost_empty_n_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            almost_full_n_q  <= 1'b1;
            almost_empty_n_q <= 1'b0;
        end else begin
            almost_full_n_q  <= !(int'(count_d) >= AF_LEVEL);
            almost_empty_n_q <= !(int'(count_d) <= AE_LEVEL);
        end
    end

    assign fifo.if_almost_full_n  = almost_full_n_q;
    assign fifo.if_almost_empty_n = almost_empty_n_q;
`endif

endmodule

// File: doc/srl_fifo_ctrl.md
SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, shift-register address width.
REQ-003 SHALL have parameter DEPTH, default 16, entry capacity; SHALL equal 2**ADDR_WIDTH or less, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port if_write_ce  input  1  write-side clock enable.
REQ-007 SHALL have port if_write  input  1  write request.
REQ-008 SHALL have port if_din  input  DATA_WIDTH  write data.
REQ-009 SHALL have port if_full_n  output  1  high when at least one entry is free.
REQ-010 SHALL have port if_read_ce  input  1  read-side clock enable.
REQ-011 SHALL have port if_read  input  1  read request.
REQ-012 SHALL have port if_dout  output  DATA_WIDTH  head-of-queue data.
REQ-013 SHALL have port if_empty_n  output  1  high when at least one entry is held.
REQ-014 SHALL have port if_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-015 push SHALL be accepted when if_write & if_write_ce & if_full_n; pop SHALL be accepted when if_read & if_read_ce & if_empty_n.
REQ-016 accepted push SHALL shift the storage one place and load if_din into entry 0 on the same edge.
REQ-017 occupancy SHALL update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-018 if_dout SHALL be combinational from storage entry (count-1): first-word fall-through, zero read latency.
REQ-019 if_dout SHALL be all-zero whenever if_empty_n is 0.
REQ-020 if_full_n and if_empty_n SHALL be registered; they SHALL be computed from next-state occupancy, so a push at edge t sets if_empty_n at t+1.
REQ-021 if_full_n SHALL be 0 exactly when occupancy equals DEPTH; if_empty_n SHALL be 0 exactly when occupancy is 0.
REQ-022 push requested while full SHALL be ignored: no shift, no count change. Pop requested while empty SHALL be ignored.
REQ-023 simultaneous push and pop at occupancy 1..DEPTH-1 SHALL shift storage and keep the read address, so if_dout advances to the next-oldest entry.
REQ-024 simultaneous push and pop at occupancy 0 or DEPTH SHALL reduce to the single legal operation per REQ-022.
REQ-025 the FIFO SHALL preserve strict first-in first-out order under any legal interleaving.

Reset
REQ-026 while reset_n is low at an edge: occupancy 0, if_count 0, if_full_n 1, if_empty_n 0, if_dout 0.
REQ-027 storage contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all held entries and ignore push/pop in that cycle.

Configuration
REQ-028 macro SRL_FIFO_CTRL_ALMOST_EN defined: SHALL add parameters AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 1), plus registered outputs if_almost_full_n (0 when occupancy >= AF_LEVEL) and if_almost_empty_n (0 when occupancy <= AE_LEVEL); reset values 1 and 0 respectively.
REQ-029 macro undefined: those parameters and ports SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 shared package srl_fifo_pkg SHALL hold the occupancy-width helper function (clog2-based) and the push/pop operation encoding constants (NOP, PUSH, POP, PUSHPOP).
REQ-031 storage SHALL be one sub-module, srl_fifo_shiftreg: write-enabled shift chain with addressed combinational read and no reset, inferable as SRL; all control logic SHALL sit in srl_fifo_ctrl.

Verification (DATA_WIDTH=8, DEPTH=16)
REQ-032 reset then idle: if_count=0, if_full_n=1, if_empty_n=0, if_dout=0x00.
REQ-033 push 0x01..0x10 on consecutive cycles: if_empty_n=1 one cycle after first push; if_full_n=0 and if_count=16 after 16th; 17th push 0xAA ignored, count stays 16.
REQ-034 from full, pop 16 times: if_dout sequence 0x01..0x10; if_empty_n=0 and if_dout=0x00 after last pop; extra pop leaves count 0.
REQ-035 hold count 5 with head 0x20, push 0x30 and pop together for 10 cycles: count stays 5, if_dout advances one entry per cycle, FIFO order kept.
REQ-036 count 7, assert reset_n low one cycle with if_write=1: count 0, if_empty_n=0 next cycle, pushed value absent.
REQ-037 if_write_ce=0 with if_write=1 for 4 cycles: count unchanged; with SRL_FIFO_CTRL_ALMOST_EN defined, 14 pushes drive if_almost_full_n to 0 and a pop to count 1 drives if_almost_empty_n to 0.
